// File: rtl/memory_access_pkg.sv
// Shared encodings for the data-side load/store engine: funct3 codes, FSM states, lane masks.
// Optional feature macro used by memory_access_unit: MISALIGN_TRAP_EN.
package memory_access_pkg;

  // Store ops reuse the load encodings: SB=FN_B, SH=FN_H, SW=FN_W.
  typedef enum logic [2:0] {
    FN_B  = 3'b000,
    FN_H  = 3'b001,
    FN_W  = 3'b010,
    FN_BU = 3'b100,
    FN_HU = 3'b101
  } funct3_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MERGE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic [31:0] LANE_MASK_B = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_H = 32'h0000_FFFF;
  localparam logic [31:0] LANE_MASK_W = 32'hFFFF_FFFF;

  function automatic logic funct3_illegal(input logic write, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (write && f3[2]);
  endfunction

endpackage

// File: rtl/load_store_lane.sv
// Combinational byte-lane logic: merges sub-word store data into an old word and
// selects/extends the addressed lane of a word for loads.
module load_store_lane
  import memory_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byteOffset,
  input  logic [31:0] oldWord,
  input  logic [31:0] storeData,
  output logic [31:0] mergedWord,
  output logic [31:0] loadData
);

  logic [4:0]  shift;
  logic [31:0] mask;
  logic [31:0] shifted;

  always_comb begin
    shift = 5'd0;
    mask  = LANE_MASK_W;
    // Halfwords ignore byteOffset[0], which aligns misaligned accesses down.
    case (funct3[1:0])
      2'b00:   begin shift = {byteOffset, 3'b000};        mask = LANE_MASK_B; end
      2'b01:   begin shift = {byteOffset[1], 4'b0000};    mask = LANE_MASK_H; end
      default: begin shift = 5'd0;                        mask = LANE_MASK_W; end
    endcase
    mergedWord = (oldWord & ~(mask << shift)) | ((storeData & mask) << shift);
    shifted    = oldWord >> shift;
    case (funct3)
      FN_B:    loadData = {{24{shifted[7]}}, shifted[7:0]};
      FN_H:    loadData = {{16{shifted[15]}}, shifted[15:0]};
      FN_BU:   loadData = {24'd0, shifted[7:0]};
      FN_HU:   loadData = {16'd0, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// RV32I load/store engine in front of a 32-bit word RAM (sub-word stores via read-modify-write).
// Define MISALIGN_TRAP_EN to report misaligned halfword/word accesses as errors instead of aligning down.
module memory_access_unit
  import memory_access_pkg::*;
#(
  parameter int RAM_A_WIDTH = 12
) (
  input  logic                   clock,
  input  logic                   nReset,
  input  logic                   reqValid,
  output logic                   reqReady,
  input  logic                   reqWrite,
  input  logic [2:0]             reqFunct3,
  input  logic [31:0]            reqAddress,
  input  logic [31:0]            reqWriteData,
  output logic                   rspValid,
  output logic [31:0]            rspData,
  output logic                   rspError,
  output logic [RAM_A_WIDTH-1:0] ramWriteAddress,
  output logic [31:0]            ramDataIn,
  output logic                   ramWriteEnable,
  output logic [RAM_A_WIDTH-1:0] ramReadAddress,
  input  logic [31:0]            ramDataOut,
  output logic [1:0]             debugState
);

  // Handshake: a request transfers on a rising edge where reqValid and reqReady are both high;
  // the response is a single-cycle rspValid pulse that cannot be stalled.

  logic [1:0]             state;
  logic                   lat_write;
  logic [2:0]             lat_funct3;
  logic [1:0]             lat_offset;
  logic [RAM_A_WIDTH-1:0] lat_word;
  logic [31:0]            lat_data;

  logic                   accept;
  logic                   req_err;
  logic                   req_sw;
  logic [RAM_A_WIDTH-1:0] req_word;
  logic [RAM_A_WIDTH-1:0] cur_word;
  logic [31:0]            merged_word;
  logic [31:0]            load_data;
  logic                   unused_addr_bits;

  assign reqReady   = (state == ST_IDLE);
  assign rspValid   = (state == ST_RESP);
  assign debugState = state;
  assign accept     = reqValid & reqReady;
  assign req_word   = reqAddress[RAM_A_WIDTH+1:2];
  assign req_sw     = reqWrite && (reqFunct3 == FN_W);
  assign unused_addr_bits = ^reqAddress[31:RAM_A_WIDTH+2];

`ifdef MISALIGN_TRAP_EN
  assign req_err = funct3_illegal(reqWrite, reqFunct3) ||
                   ((reqFunct3[1:0] == 2'b01) && reqAddress[0]) ||
                   ((reqFunct3[1:0] == 2'b10) && (reqAddress[1:0] != 2'b00));
`else
  assign req_err = funct3_illegal(reqWrite, reqFunct3);
`endif

  // The RAM is addressed straight from the request while idle so MERGE sees the old word.
  assign cur_word        = reqReady ? req_word : lat_word;
  assign ramReadAddress  = cur_word;
  assign ramWriteAddress = cur_word;
  assign ramWriteEnable  = (accept && req_sw && !req_err) || ((state == ST_MERGE) && lat_write);
  assign ramDataIn       = (state == ST_MERGE) ? merged_word : reqWriteData;

  load_store_lane u_lane (
    .funct3     (lat_funct3),
    .byteOffset (lat_offset),
    .oldWord    (ramDataOut),
    .storeData  (lat_data),
    .mergedWord (merged_word),
    .loadData   (load_data)
  );

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state      <= ST_IDLE;
      rspData    <= 32'd0;
      rspError   <= 1'b0;
      lat_write  <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_offset <= 2'd0;
      lat_word   <= '0;
      lat_data   <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_write  <= reqWrite;
            lat_funct3 <= reqFunct3;
            lat_offset <= reqAddress[1:0];
            lat_word   <= req_word;
            lat_data   <= reqWriteData;
            if (req_err || req_sw) begin
              rspError <= req_err;
              rspData  <= 32'd0;
              state    <= ST_RESP;
            end else begin
              state <= ST_MERGE;
            end
          end
        end
        ST_MERGE: begin
          rspData  <= lat_write ? 32'd0 : load_data;
          rspError <= 1'b0;
          state    <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a behavioural 1-cycle-latency word RAM.
module tb_memory_access_unit;

  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          nReset = 1'b0;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic          reqWrite = 1'b0;
  logic [2:0]    reqFunct3 = 3'd0;
  logic [31:0]   reqAddress = 32'd0;
  logic [31:0]   reqWriteData = 32'd0;
  logic          rspValid;
  logic [31:0]   rspData;
  logic          rspError;
  logic [AW-1:0] ramWriteAddress;
  logic [31:0]   ramDataIn;
  logic          ramWriteEnable;
  logic [AW-1:0] ramReadAddress;
  logic [31:0]   ramDataOut;
  logic [1:0]    debugState;

  logic [31:0] mem [0:(1<<AW)-1];
  int          wr_count = 0;
  int          checks = 0;
  int          failures = 0;

  memory_access_unit #(.RAM_A_WIDTH(AW)) dut (
    .clock           (clock),
    .nReset          (nReset),
    .reqValid        (reqValid),
    .reqReady        (reqReady),
    .reqWrite        (reqWrite),
    .reqFunct3       (reqFunct3),
    .reqAddress      (reqAddress),
    .reqWriteData    (reqWriteData),
    .rspValid        (rspValid),
    .rspData         (rspData),
    .rspError        (rspError),
    .ramWriteAddress (ramWriteAddress),
    .ramDataIn       (ramDataIn),
    .ramWriteEnable  (ramWriteEnable),
    .ramReadAddress  (ramReadAddress),
    .ramDataOut      (ramDataOut),
    .debugState      (debugState)
  );

  // clock / reset
  always #5 clock = ~clock;

  // RAM: registered read port B, write port
  always @(posedge clock) begin
    if (ramWriteEnable) begin
      mem[ramWriteAddress] <= ramDataIn;
      wr_count = wr_count + 1;
    end
    ramDataOut <= mem[ramReadAddress];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] data,
                        output logic err, output int lat);
    @(negedge clock);
    reqValid = 1'b1; reqWrite = wr; reqFunct3 = f3;
    reqAddress = addr; reqWriteData = wdata;
    @(negedge clock);
    reqValid = 1'b0;
    lat = 1;
    while (!rspValid && lat < 8) begin
      @(negedge clock);
      lat++;
    end
    data = rspData;
    err  = rspError;
    @(negedge clock);
    check("rsp_pulse_one_cycle", {31'd0, rspValid}, 32'd0);
  endtask

  task automatic run(input string tag, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    logic [31:0] d;
    logic        e;
    int          l;
    do_req(wr, f3, addr, wdata, d, e, l);
    check({tag, "_data"}, d, exp_data);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    check({tag, "_lat"}, l, exp_lat);
  endtask

  int w0;
  int seen;

  initial begin
    repeat (2) @(negedge clock);
    check("reset_rspValid", {31'd0, rspValid}, 32'd0);
    check("reset_wen", {31'd0, ramWriteEnable}, 32'd0);
    nReset = 1'b1;
    @(negedge clock);
    check("reset_ready", {31'd0, reqReady}, 32'd1);
    check("reset_rspData", rspData, 32'd0);
    check("reset_rspError", {31'd0, rspError}, 32'd0);

    run("sw_init20", 1, 3'b010, 32'h20, 32'h0, 32'h0, 0, 1);
    run("sw_dead",   1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
    run("lw_dead",   0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);
    run("sw_1122",   1, 3'b010, 32'h10, 32'h11223344, 32'h0, 0, 1);
    run("sb_80",     1, 3'b000, 32'h13, 32'h12345680, 32'h0, 0, 2);
    run("lb_13",     0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0, 2);
    run("lbu_13",    0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0, 2);
    run("lw_after_sb", 0, 3'b010, 32'h10, 32'h0, 32'h80223344, 0, 2);
    run("lb_11",     0, 3'b000, 32'h11, 32'h0, 32'h00000033, 0, 2);
    run("sh_abcd",   1, 3'b001, 32'h22, 32'h5555ABCD, 32'h0, 0, 2);
    run("lhu_22",    0, 3'b101, 32'h22, 32'h0, 32'h0000ABCD, 0, 2);
    run("lh_22",     0, 3'b001, 32'h22, 32'h0, 32'hFFFFABCD, 0, 2);
    run("lw_after_sh", 0, 3'b010, 32'h20, 32'h0, 32'hABCD0000, 0, 2);
    run("lw_wrap",   0, 3'b010, 32'h00004010, 32'h0, 32'h80223344, 0, 2);

    w0 = wr_count;
`ifdef MISALIGN_TRAP_EN
    run("lw_misaligned", 0, 3'b010, 32'h11, 32'h0, 32'h0, 1, 1);
    run("sw_misaligned", 1, 3'b010, 32'h12, 32'h99999999, 32'h0, 1, 1);
`else
    run("lw_misaligned", 0, 3'b010, 32'h11, 32'h0, 32'h80223344, 0, 2);
    run("lh_misaligned", 0, 3'b001, 32'h23, 32'h0, 32'hFFFFABCD, 0, 2);
    w0 = wr_count;
`endif
    run("st_f3_011", 1, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1);
    run("ld_f3_110", 0, 3'b110, 32'h10, 32'h0, 32'h0, 1, 1);
    run("st_f3_100", 1, 3'b100, 32'h10, 32'h0, 32'h0, 1, 1);
    check("err_no_write", wr_count, w0);
    run("lw_after_err", 0, 3'b010, 32'h10, 32'h0, 32'h80223344, 0, 2);

    // Reset while an SB sits in MERGE
    @(negedge clock);
    reqValid = 1'b1; reqWrite = 1'b1; reqFunct3 = 3'b000;
    reqAddress = 32'h12; reqWriteData = 32'h77;
    @(negedge clock);
    reqValid = 1'b0;
    check("sb_in_merge", {30'd0, debugState}, 32'd1);
    w0 = wr_count;
    nReset = 1'b0;
    #1;
    check("rst_merge_wen", {31'd0, ramWriteEnable}, 32'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clock);
      if (rspValid) seen++;
    end
    nReset = 1'b1;
    #1;
    check("rst_release_ready", {31'd0, reqReady}, 32'd1);
    repeat (3) begin
      @(negedge clock);
      if (rspValid) seen++;
    end
    check("rst_no_rsp", seen, 0);
    check("rst_no_write", wr_count, w0);
    run("lw_after_rst", 0, 3'b010, 32'h10, 32'h0, 32'h80223344, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
